// File: rtl/apb_demux_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_demux_sync : address-decoding APB demux, decode-error/timeout replies  |
// | Option macro: APB_DEMUX_SYNC_TIMEOUT_EN           Rev 1.0                  |
// +----------------------------------------------------------------------------+
module apb_demux_sync #(
  parameter int unsigned NoMstPorts    = 2,
  parameter int unsigned NoAddrRules   = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16,
  parameter type req_t = struct packed {
    logic [AddrWidth-1:0]   paddr;
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [DataWidth-1:0]   pwdata;
    logic [DataWidth/8-1:0] pstrb;
  },
  parameter type resp_t = struct packed {
    logic                 pready;
    logic [DataWidth-1:0] prdata;
    logic                 pslverr;
  },
  parameter int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  req_t                   slv_req_i,
  output resp_t                  slv_resp_o,
  output req_t                   mst_req_o    [NoMstPorts],
  input  resp_t                  mst_resp_i   [NoMstPorts],
  input  logic [AddrWidth-1:0]   rule_start_i [NoAddrRules],
  input  logic [AddrWidth-1:0]   rule_end_i   [NoAddrRules],
  input  logic [SelectWidth-1:0] rule_idx_i   [NoAddrRules],
  output logic                   busy_o,
  output logic                   decode_err_o,
  output logic                   timeout_o
);

  generate
    if (NoMstPorts < 1 || NoAddrRules < 1 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_param_check
      $error("apb_demux_sync: parameter out of range");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FWD   = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;
`ifdef APB_DEMUX_SYNC_TIMEOUT_EN
  localparam logic [1:0] ST_ABORT = 2'd3;
`endif
  localparam logic [SelectWidth:0] NUM_PORTS = (SelectWidth + 1)'(NoMstPorts);

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [SelectWidth-1:0] sel_q;
  logic [SelectWidth-1:0] hit_idx;
  logic                   hit;
  logic                   err_done;
  logic                   decode_err_q;
  resp_t                  sel_resp;

  // Lowest-index rule wins; empty ranges and out-of-range targets never hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = 0; r < NoAddrRules; r++) begin
      if (!hit && (rule_start_i[r] < rule_end_i[r]) &&
          (slv_req_i.paddr >= rule_start_i[r]) && (slv_req_i.paddr < rule_end_i[r]) &&
          ({1'b0, rule_idx_i[r]} < NUM_PORTS)) begin
        hit     = 1'b1;
        hit_idx = rule_idx_i[r];
      end
    end
  end

  always_comb begin
    sel_resp = '0;
    for (int p = 0; p < NoMstPorts; p++) begin
      if (sel_q == SelectWidth'(p)) sel_resp = mst_resp_i[p];
    end
  end

  assign err_done = (state_q == ST_ERR) && slv_req_i.psel && slv_req_i.penable;

`ifdef APB_DEMUX_SYNC_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TimeoutCycles + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TimeoutCycles);

  logic [CNT_WIDTH-1:0] wait_cnt_q;
  logic                 limit_hit;
  logic                 timeout_q;

  assign limit_hit = (wait_cnt_q == CNT_LIMIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (state_q != ST_FWD || state_d != ST_FWD) begin
      wait_cnt_q <= '0;
    end else if (slv_req_i.penable && !sel_resp.pready && !limit_hit) begin
      wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) timeout_q <= 1'b0;
    else       timeout_q <= (state_q == ST_ABORT);
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      decode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      decode_err_q <= err_done;
      if (state_q == ST_IDLE && slv_req_i.psel && hit) sel_q <= hit_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (slv_req_i.psel) state_d = hit ? ST_FWD : ST_ERR;
      end
      ST_FWD: begin
        if (!slv_req_i.psel)                               state_d = ST_IDLE;
        else if (slv_req_i.penable && sel_resp.pready)     state_d = ST_IDLE;
`ifdef APB_DEMUX_SYNC_TIMEOUT_EN
        else if (slv_req_i.penable && limit_hit)           state_d = ST_ABORT;
`endif
      end
      ST_ERR: begin
        if (!slv_req_i.psel || slv_req_i.penable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Master select is gated by reset so an upstream still holding psel cannot leak through.
  always_comb begin
    slv_resp_o = '0;
    for (int p = 0; p < NoMstPorts; p++) begin
      mst_req_o[p]         = slv_req_i;
      mst_req_o[p].psel    = 1'b0;
      mst_req_o[p].penable = 1'b0;
    end
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          for (int p = 0; p < NoMstPorts; p++) begin
            if (slv_req_i.psel && hit && hit_idx == SelectWidth'(p)) mst_req_o[p].psel = 1'b1;
          end
        end
        ST_FWD: begin
          for (int p = 0; p < NoMstPorts; p++) begin
            if (sel_q == SelectWidth'(p)) begin
              mst_req_o[p].psel    = slv_req_i.psel;
              mst_req_o[p].penable = slv_req_i.penable;
            end
          end
          slv_resp_o = sel_resp;
        end
        ST_ERR: begin
          if (err_done) begin
            slv_resp_o.pready  = 1'b1;
            slv_resp_o.pslverr = 1'b1;
          end
        end
`ifdef APB_DEMUX_SYNC_TIMEOUT_EN
        ST_ABORT: begin
          slv_resp_o.pready  = 1'b1;
          slv_resp_o.pslverr = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign decode_err_o = decode_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_demux_sync.sv
`default_nettype none
// Scoreboard bench for apb_demux_sync: directed scenarios plus randomized transfers.
module tb_apb_demux_sync;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NP = 3;
  localparam int NR = 4;
  localparam int TO = 4;
  localparam int SW = 2;
`ifdef APB_DEMUX_SYNC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
  } req_t;
  typedef struct packed {
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
  } resp_t;
  typedef struct {
    int            tgt;
    bit            tmo;
    bit            err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  logic          clk, rst;
  req_t          slv_req;
  resp_t         slv_resp;
  req_t          mst_req  [NP];
  resp_t         mst_resp [NP];
  logic [AW-1:0] rule_start [NR];
  logic [AW-1:0] rule_end   [NR];
  logic [SW-1:0] rule_idx   [NR];
  logic          busy, derr, tout;

  int            wait_cfg  [NP];
  logic [DW-1:0] rdata_cfg [NP];
  bit            perr_cfg  [NP];
  int            acnt      [NP];
  exp_t          exp_q[$];
  int            n_chk, n_fail;

  bit            mon_active, exp_derr_nx, exp_to_nx, done;
  int            mon_acc;
  logic [NP-1:0] ev, gv, gen;
  exp_t          me;

  apb_demux_sync #(
    .NoMstPorts(NP), .NoAddrRules(NR), .AddrWidth(AW), .DataWidth(DW),
    .TimeoutCycles(TO), .req_t(req_t), .resp_t(resp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .rule_start_i(rule_start), .rule_end_i(rule_end), .rule_idx_i(rule_idx),
    .busy_o(busy), .decode_err_o(derr), .timeout_o(tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: first enabled rule containing the address with a valid port index.
  function automatic int decode(input logic [AW-1:0] a);
    for (int r = 0; r < NR; r++)
      if (rule_start[r] < rule_end[r] && a >= rule_start[r] && a < rule_end[r] && int'(rule_idx[r]) < NP)
        return int'(rule_idx[r]);
    return -1;
  endfunction

  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    e.tgt = decode(a);
    if (e.tgt < 0) begin
      e.tmo = 1'b0; e.err = 1'b1; e.rdata = '0; e.lat = 1;
    end else if (TO_EN && wait_cfg[e.tgt] > TO) begin
      e.tmo = 1'b1; e.err = 1'b1; e.rdata = '0; e.lat = TO + 2;
    end else begin
      e.tmo = 1'b0; e.err = perr_cfg[e.tgt]; e.rdata = rdata_cfg[e.tgt]; e.lat = wait_cfg[e.tgt] + 1;
    end
    return e;
  endfunction

  // Downstream slaves: ready after wait_cfg access cycles.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (mst_req[p].psel && mst_req[p].penable) begin
        mst_resp[p].pready  = (acnt[p] >= wait_cfg[p]);
        mst_resp[p].prdata  = mst_resp[p].pready ? rdata_cfg[p] : '0;
        mst_resp[p].pslverr = mst_resp[p].pready ? perr_cfg[p] : 1'b0;
        acnt[p]++;
      end else begin
        mst_resp[p] = '0;
        acnt[p]     = 0;
      end
    end
  end

  // Monitor: per-cycle status/select checks and scoreboard pop on completion.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        mon_active = 1'b0; mon_acc = 0; exp_derr_nx = 1'b0; exp_to_nx = 1'b0;
        continue;
      end
      chk("busy", 64'(busy), 64'(mon_active));
      chk("decode_err_pulse", 64'(derr), 64'(exp_derr_nx));
      chk("timeout_pulse", 64'(tout), 64'(exp_to_nx));
      exp_derr_nx = 1'b0; exp_to_nx = 1'b0;
      done = slv_req.psel && slv_req.penable && slv_resp.pready;
      ev = '0;
      if (slv_req.psel && exp_q.size() > 0 && exp_q[0].tgt >= 0 && !(done && exp_q[0].tmo))
        ev[exp_q[0].tgt] = 1'b1;
      for (int p = 0; p < NP; p++) begin
        gv[p]  = mst_req[p].psel;
        gen[p] = mst_req[p].penable;
      end
      chk("mst_psel_vec", 64'(gv), 64'(ev));
      chk("mst_penable_vec", 64'(gen), 64'(ev & {NP{slv_req.penable}}));
      if (slv_req.psel && slv_req.penable) mon_acc++;
      else mon_acc = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 64'(1), 64'(0));
        end else begin
          me = exp_q.pop_front();
          chk("prdata", 64'(slv_resp.prdata), 64'(me.rdata));
          chk("pslverr", 64'(slv_resp.pslverr), 64'(me.err));
          chk("access_cycles", 64'(mon_acc), 64'(me.lat));
          for (int p = 0; p < NP; p++)
            chk("broadcast", 64'({mst_req[p].paddr, mst_req[p].pwrite, mst_req[p].pwdata, mst_req[p].pstrb}),
                64'({slv_req.paddr, slv_req.pwrite, slv_req.pwdata, slv_req.pstrb}));
          exp_derr_nx = (me.tgt < 0);
          exp_to_nx   = me.tmo;
        end
        mon_acc = 0;
      end
      mon_active = slv_req.psel && !done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rule(input int r, input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [SW-1:0] idx);
    rule_start[r] = s; rule_end[r] = e; rule_idx[r] = idx;
  endtask

  task automatic set_port(input int p, input int w, input logic [DW-1:0] d, input bit err);
    wait_cfg[p] = w; rdata_cfg[p] = d; perr_cfg[p] = err;
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input bit wr, input bit chg, input logic [AW-1:0] alt);
    int n;
    exp_q.push_back(model(addr));
    slv_req.paddr   = addr;
    slv_req.pwrite  = wr;
    slv_req.pwdata  = $urandom;
    slv_req.pstrb   = 4'($urandom);
    slv_req.psel    = 1'b1;
    slv_req.penable = 1'b0;
    cyc(1);
    slv_req.penable = 1'b1;
    if (chg) slv_req.paddr = alt;
    n = 0;
    while (1) begin
      @(negedge clk); #3;
      if (slv_resp.pready) break;
      n++;
      if (n > 100) begin
        n_chk++; n_fail++;
        $display("FAIL xfer_watchdog: no pready after %0d access cycles, required within 100", n);
        break;
      end
    end
    cyc(1);
    slv_req.psel    = 1'b0;
    slv_req.penable = 1'b0;
  endtask

  task automatic map_default();
    set_rule(0, 16'h0000, 16'h1000, 2'd0);
    set_rule(1, 16'h1000, 16'h2000, 2'd1);
    set_rule(2, 16'h0000, 16'h0000, 2'd2);
    set_rule(3, 16'h0000, 16'h0000, 2'd2);
  endtask

  initial begin
    logic [AW-1:0] s;
    n_chk = 0; n_fail = 0;
    slv_req = '0;
    for (int p = 0; p < NP; p++) set_port(p, 0, '0, 1'b0);
    map_default();
    rst = 1'b1;
    cyc(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_decode_err", 64'(derr), 64'(0));
    chk("rst_timeout", 64'(tout), 64'(0));
    chk("rst_slv_pready", 64'(slv_resp.pready), 64'(0));
    for (int p = 0; p < NP; p++) chk("rst_mst_psel", 64'({mst_req[p].psel, mst_req[p].penable}), 64'(0));
    rst = 1'b0;
    cyc(1);

    // Mapped write to port 1 with two wait states
    set_port(1, 2, 32'h1111_2222, 1'b0);
    xfer(16'h1004, 1'b1, 1'b0, '0);
    cyc(2);

    // Overlapping rules: lower index wins
    set_rule(0, 16'h0000, 16'h2000, 2'd1);
    set_rule(1, 16'h1000, 16'h3000, 2'd0);
    set_port(0, 0, 32'hDEAD_BEEF, 1'b0);
    set_port(1, 1, 32'hCAFE_F00D, 1'b0);
    xfer(16'h1800, 1'b0, 1'b0, '0);
    cyc(1);

    // Decode miss, then a miss whose setup is abandoned by dropping psel
    xfer(16'h5000, 1'b0, 1'b0, '0);
    cyc(1);
    slv_req.paddr = 16'h5000; slv_req.psel = 1'b1; slv_req.penable = 1'b0;
    cyc(1);
    slv_req.psel = 1'b0;
    cyc(3);

    // Rule whose target index is beyond the port count is a miss
    set_rule(0, 16'h0000, 16'h1000, 2'd3);
    set_rule(1, 16'h1000, 16'h2000, 2'd1);
    xfer(16'h0800, 1'b1, 1'b0, '0);
    cyc(1);

    // Long waits: abort when enabled, plus pready exactly at the limit
    map_default();
    set_port(0, TO_EN ? 1000 : 12, 32'h0BAD_0BAD, 1'b0);
    xfer(16'h0100, 1'b0, 1'b0, '0);
    cyc(1);
    set_port(0, TO, 32'h600D_600D, 1'b1);
    xfer(16'h0104, 1'b0, 1'b0, '0);
    cyc(1);

    // Back-to-back port 0 then port 1; address moves into port 1 during port 0 access
    set_port(0, 1, 32'hAAAA_0000, 1'b0);
    set_port(1, 0, 32'hBBBB_1111, 1'b0);
    xfer(16'h0010, 1'b1, 1'b1, 16'h1004);
    xfer(16'h1008, 1'b0, 1'b0, '0);
    cyc(2);

    // Asynchronous reset in the middle of a FWD wait
    set_port(0, 20, 32'h1234_5678, 1'b0);
    exp_q.push_back(model(16'h0200));
    slv_req.paddr = 16'h0200; slv_req.pwrite = 1'b0; slv_req.psel = 1'b1; slv_req.penable = 1'b0;
    cyc(1);
    slv_req.penable = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    for (int p = 0; p < NP; p++) chk("midrst_mst_sel", 64'({mst_req[p].psel, mst_req[p].penable}), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_status", 64'({derr, tout}), 64'(0));
    slv_req.psel = 1'b0; slv_req.penable = 1'b0;
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    set_port(1, 1, 32'h5A5A_A5A5, 1'b1);
    xfer(16'h1ABC, 1'b0, 1'b0, '0);
    cyc(1);

    // Randomized transfers with periodic random address maps
    for (int i = 0; i < 80; i++) begin
      if (i % 8 == 0) begin
        for (int r = 0; r < NR; r++) begin
          s = AW'($urandom_range(0, 'h3000));
          if ($urandom_range(0, 5) == 0) set_rule(r, s, s, SW'($urandom_range(0, NP - 1)));
          else set_rule(r, s, s + AW'($urandom_range(1, 'h1800)), SW'($urandom_range(0, NP - 1)));
        end
      end
      for (int p = 0; p < NP; p++)
        set_port(p, int'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
      xfer(AW'($urandom_range(0, 'h3FFF)), 1'($urandom_range(0, 1)), 1'b0, '0);
      if ($urandom_range(0, 2) != 0) cyc(int'($urandom_range(1, 2)));
    end

    cyc(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion before 500000");
    $fatal(1);
  end

endmodule
`default_nettype wire
